// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Round-robin arbiter that shares one SPI master driver among NUM_REQ
//   requesters. A winner is picked in IDLE, its TX word is handed to the
//   driver with a one-cycle start pulse, and the arbiter follows the driver's
//   ready handshake (high -> low -> high) before returning the RX word with a
//   one-cycle done pulse to the winner.
//
//   Optional watchdog: define SPI_ARB_TIMEOUT_EN to bound the time spent
//   waiting on the driver to TIMEOUT_CYCLES clocks. Without the macro the
//   arbiter waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk          : clock, all logic on rising edge
//   rst          : synchronous active-high reset
//   req          : per-requester request level
//   req_data     : flat TX words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          : one-hot grant, held for the whole transaction
//   done         : one-cycle completion pulse to the granted requester
//   rsp_data     : RX word, valid in the done cycle, held until next capture
//   spi_start    : start pulse to the SPI master driver
//   spi_data_in  : TX word to the driver
//   spi_data_out : RX word from the driver
//   spi_ready    : driver idle/finished indication
//   busy         : high whenever the arbiter is not idle
//   timeout_err  : sticky watchdog error flag
module spi_master_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic [DATA_WIDTH-1:0]         spi_data_out,
  input  logic                          spi_ready,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LOW,
    WAIT_HIGH,
    COMPLETE
  } state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      last_winner_reg;
  logic [IDX_W-1:0]      win_idx_reg;
  logic [NUM_REQ-1:0]    gnt_reg;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] rsp_reg;
  logic                  wd_expired;

  // Unpack the flat request bus into one word per requester.
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin search: the first requester after the last winner wins, so
  // the most recently served requester has the lowest priority.
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             rr_found;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_winner_reg) + off) % NUM_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (spi_ready && rr_found) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_LOW;
      // A watchdog expiry ends the wait even if the driver never dropped ready.
      WAIT_LOW: begin
        if (wd_expired)      state_next = COMPLETE;
        else if (!spi_ready) state_next = WAIT_HIGH;
      end
      // A genuine completion wins over an expiry landing on the same cycle.
      WAIT_HIGH: begin
        if (spi_ready)       state_next = COMPLETE;
        else if (wd_expired) state_next = COMPLETE;
      end
      COMPLETE:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_winner_reg <= IDX_W'(NUM_REQ - 1);
      win_idx_reg     <= '0;
      gnt_reg         <= '0;
      tx_reg          <= '0;
      rsp_reg         <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (state_next == LAUNCH) begin
            gnt_reg     <= NUM_REQ'(1) << rr_idx;
            win_idx_reg <= rr_idx;
            tx_reg      <= req_word[rr_idx];
          end
        end
        WAIT_HIGH: begin
          if (spi_ready) rsp_reg <= spi_data_out;
        end
        COMPLETE: begin
          gnt_reg         <= '0;
          last_winner_reg <= win_idx_reg;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_err_reg;
  logic            in_wait;

  assign in_wait    = (state_reg == WAIT_LOW) || (state_reg == WAIT_HIGH);
  // Counter is 0 on the first wait cycle, so expiry lands on the
  // TIMEOUT_CYCLES-th cycle spent waiting.
  assign wd_expired = in_wait && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (in_wait) wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      else         wd_cnt_reg <= '0;
      if (wd_expired && !(state_reg == WAIT_HIGH && spi_ready))
        timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign gnt         = gnt_reg;
  assign done        = (state_reg == COMPLETE) ? gnt_reg : '0;
  assign spi_start   = (state_reg == LAUNCH);
  assign busy        = (state_reg != IDLE);
  assign spi_data_in = tx_reg;
  assign rsp_data    = rsp_reg;

endmodule
